jtdsp16_pc_seq: RTL and testbench
=================================

// Module: jtdsp16_pc_seq
// PURPOSE
//  Parametrised program sequencer (XAAU successor) for the DSP16 core: owns the ROM program counter,
//  an N-deep return stack, the do-loop (cache) repeat counter and interrupt entry/exit via PI.
//  Sits between jtdsp16_ctrl (decoded strobes) and jtdsp16_rom / ext_addr (rom_addr output).
// PARAMETERS
//  AW          16      program address width (i_field replaces the low 12 bits)
//  STACK_DEPTH 4       return-stack entries (>=1)
//  CNTW        7       do-loop repeat counter width (K up to 2**CNTW-1)
//  IRQ_VEC     16'h1   address loaded on interrupt entry
//  ICALL_VEC   16'h2   address loaded on icall
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous reset, active high
//  cen         in   1        clock enable; all state updates only when cen=1
//  goto_ja     in   1        jump to {pc[AW-1:12],i_field}
//  call_ja     in   1        push pc+1, then jump as goto_ja
//  goto_b      in   1        B-type branch, kind chosen by b_field
//  b_field     in   2        0 return(pop) 1 ireturn(PI) 2 goto pt 3 call pt
//  icall       in   1        software interrupt: PI<=pc+1, pc<=ICALL_VEC
//  post_inc    in   1        sequential instruction: pc<=pc+1
//  i_field     in   12       jump target low bits
//  pt          in   AW       PT register value for goto/call pt
//  con_result  in   1        branch strobes execute only when 1; else treated as post_inc
//  do_en       in   1        start loop: repeat next do_ni instructions do_k times
//  do_ni       in   4        loop body length, 1..15
//  do_k        in   CNTW     repeat count, >=2
//  ext_irq     in   1        external interrupt request (level)
//  rom_addr    out  AW       program counter
//  shadow      out  1        current instruction is non-interruptible
//  in_loop     out  1        loop active
//  stack_empty out  1        no stack entries
//  stack_ovf   out  1        sticky: push attempted while full
// BEHAVIOUR
//  Reset: rom_addr=0, PI=0, stack pointer 0, stack_empty=1, stack_ovf=0, in_loop=0, shadow=0, irq_busy=0.
//  All outputs registered; a strobe at cen edge n is reflected on rom_addr after edge n (latency 1).
//  Priority per cen cycle: irq entry > executed branch (goto_ja/call_ja/goto_b/icall) > loop wrap > post_inc.
//  Strobes are one-hot; none asserted => pc holds. Branch with con_result=0 => pc+1.
//  Arithmetic: pc+1 wraps modulo 2**AW; loop end = start+do_ni-1 modulo 2**AW.
//  Stack: push writes entry[sp], sp++. Push when full: drop oldest (circular shift), stack_ovf<=1, sp unchanged.
//   Pop when empty: pc<=0, sp stays 0. Push and pop never coincide (single strobe).
//  ireturn: pc<=PI, irq_busy<=0. call pt: push pc+1, pc<=pt.
//  Loop: do_en at pc=A => start=A+1, end=A+do_ni, cnt=do_k, in_loop=1, pc<=A+1.
//   When in_loop and pc==end and post_inc: cnt>1 => pc<=start, cnt--; cnt==1 => pc<=end+1, in_loop<=0.
//   Executed branch while in_loop cancels the loop (in_loop<=0) and branch target wins.
//   do_en while in_loop is ignored (no nesting); pc advances normally.
//  shadow=1 for the cen cycle following any executed branch, icall, irq entry or do_en.
//  rst mid-loop or mid-interrupt returns all state to reset values on the same edge.
// CONFIGURATION
//  JTDSP16_IRQ_EN defined: ext_irq accepted when ext_irq=1, irq_busy=0, shadow=0, in_loop=0 and a
//   post_inc is presented: PI<=pc+1, pc<=IRQ_VEC, irq_busy<=1; instruction's own strobe discarded.
//  Not defined: ext_irq ignored, irq_busy tied 0; icall and ireturn still work via PI.
// TESTING
//  Reset then 5 post_inc -> rom_addr 0,1,2,3,4,5; stack_empty=1, shadow=0 throughout.
//  pc=0x10, call_ja i_field=0x123 -> pc=0x123, shadow=1 one cycle; goto_b b_field=0 -> pc=0x11, stack_empty=1.
//  STACK_DEPTH=4: 5 nested calls from 0x20..0x24 -> stack_ovf=1; 4 returns -> 0x25,0x24,0x23,0x22; 5th return -> 0.
//  pc=0x40 do_en ni=3 k=2, post_inc -> pc 0x41,42,43,41,42,43,44; in_loop falls with pc=0x44.
//  In loop at 0x42, goto_ja con_result=1 i_field=0x080 -> pc=0x080, in_loop=0; con_result=0 -> pc=0x43.
//  IRQ_EN: ext_irq at pc=0x30 -> pc=IRQ_VEC, PI=0x31; ext_irq held, no re-entry; ireturn -> pc=0x31.

Source files
------------

// File: rtl/jtdsp16_pc_seq.sv
// DSP16 program sequencer: PC, return stack, do-loop repeat counter, PI-based interrupt entry/exit.
// Optional external interrupt entry is enabled by defining JTDSP16_IRQ_EN.
module jtdsp16_pc_seq #(
  parameter int AW = 16,
  parameter int STACK_DEPTH = 4,
  parameter int CNTW = 7,
  parameter logic [AW-1:0] IRQ_VEC = AW'(1),
  parameter logic [AW-1:0] ICALL_VEC = AW'(2)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cen_i,
  input  logic            goto_ja_i,
  input  logic            call_ja_i,
  input  logic            goto_b_i,
  input  logic [1:0]      b_field_i,
  input  logic            icall_i,
  input  logic            post_inc_i,
  input  logic [11:0]     i_field_i,
  input  logic [AW-1:0]   pt_i,
  input  logic            con_result_i,
  input  logic            do_en_i,
  input  logic [3:0]      do_ni_i,
  input  logic [CNTW-1:0] do_k_i,
  input  logic            ext_irq_i,
  output logic [AW-1:0]   rom_addr_o,
  output logic            shadow_o,
  output logic            in_loop_o,
  output logic            stack_empty_o,
  output logic            stack_ovf_o
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);

  logic [AW-1:0]   pc_q, pc_d, pi_q, pi_d, start_q, start_d, end_q, end_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic [AW-1:0]   stk_q [STACK_DEPTH];
  logic [AW-1:0]   stk_d [STACK_DEPTH];
  logic            ovf_q, ovf_d, loop_q, loop_d, shadow_q, shadow_d;
  logic [AW-1:0]   pc_inc, jump_tgt, stk_top;
  logic            any_br, br_x, seq, do_start, push_en, irq_take;

  assign pc_inc   = pc_q + AW'(1);
  assign jump_tgt = {pc_q[AW-1:12], i_field_i};
  assign any_br   = goto_ja_i | call_ja_i | goto_b_i | icall_i;
  assign br_x     = any_br & con_result_i;
  assign do_start = do_en_i & ~loop_q;
  // Anything that simply advances: post_inc, a skipped branch, or a do_en ignored inside a loop.
  assign seq      = post_inc_i | (any_br & ~con_result_i) | (do_en_i & loop_q);

`ifdef JTDSP16_IRQ_EN
  logic busy_q, busy_d;
  assign irq_take = ext_irq_i & ~busy_q & ~shadow_q & ~loop_q & post_inc_i;

  always_comb begin
    busy_d = busy_q;
    if (cen_i) begin
      if (irq_take) busy_d = 1'b1;
      else if (br_x & goto_b_i & (b_field_i == 2'd1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= 1'b0;
    else       busy_q <= busy_d;
  end
`else
  logic irq_unused;
  assign irq_unused = ext_irq_i;
  assign irq_take   = 1'b0;
`endif

  always_comb begin
    stk_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (SPW'(i + 1) == sp_q) stk_top = stk_q[i];
  end

  always_comb begin
    pc_d     = pc_q;
    pi_d     = pi_q;
    start_d  = start_q;
    end_d    = end_q;
    cnt_d    = cnt_q;
    sp_d     = sp_q;
    stk_d    = stk_q;
    ovf_d    = ovf_q;
    loop_d   = loop_q;
    shadow_d = shadow_q;
    push_en  = 1'b0;
    if (cen_i) begin
      shadow_d = br_x | do_en_i | irq_take;
      if (irq_take) begin
        pi_d = pc_inc;
        pc_d = IRQ_VEC;
      end else if (br_x) begin
        loop_d = 1'b0;
        if (goto_ja_i) begin
          pc_d = jump_tgt;
        end else if (call_ja_i) begin
          push_en = 1'b1;
          pc_d    = jump_tgt;
        end else if (icall_i) begin
          pi_d = pc_inc;
          pc_d = ICALL_VEC;
        end else begin
          case (b_field_i)
            2'd0: begin
              pc_d = (sp_q == '0) ? '0 : stk_top;
              if (sp_q != '0) sp_d = sp_q - SPW'(1);
            end
            2'd1: pc_d = pi_q;
            2'd2: pc_d = pt_i;
            default: begin
              push_en = 1'b1;
              pc_d    = pt_i;
            end
          endcase
        end
      end else if (do_start) begin
        start_d = pc_inc;
        end_d   = pc_q + AW'(do_ni_i);
        cnt_d   = do_k_i;
        loop_d  = 1'b1;
        pc_d    = pc_inc;
      end else if (seq) begin
        if (loop_q && pc_q == end_q) begin
          if (cnt_q > CNTW'(1)) begin
            pc_d  = start_q;
            cnt_d = cnt_q - CNTW'(1);
          end else begin
            pc_d   = pc_inc;
            loop_d = 1'b0;
          end
        end else begin
          pc_d = pc_inc;
        end
      end
    end
    // A full stack keeps the newest entries: shift out the oldest, stick the overflow flag.
    if (push_en) begin
      if (sp_q == SPW'(STACK_DEPTH)) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) stk_d[i] = stk_q[i + 1];
        stk_d[STACK_DEPTH-1] = pc_inc;
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < STACK_DEPTH; i++)
          if (SPW'(i) == sp_q) stk_d[i] = pc_inc;
        sp_d = sp_q + SPW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= '0;
      pi_q     <= '0;
      start_q  <= '0;
      end_q    <= '0;
      cnt_q    <= '0;
      sp_q     <= '0;
      stk_q    <= '{default: '0};
      ovf_q    <= 1'b0;
      loop_q   <= 1'b0;
      shadow_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pi_q     <= pi_d;
      start_q  <= start_d;
      end_q    <= end_d;
      cnt_q    <= cnt_d;
      sp_q     <= sp_d;
      stk_q    <= stk_d;
      ovf_q    <= ovf_d;
      loop_q   <= loop_d;
      shadow_q <= shadow_d;
    end
  end

  assign rom_addr_o    = pc_q;
  assign shadow_o      = shadow_q;
  assign in_loop_o     = loop_q;
  assign stack_empty_o = (sp_q == '0);
  assign stack_ovf_o   = ovf_q;

endmodule

// File: tb/tb_jtdsp16_pc_seq.sv
// Bench for jtdsp16_pc_seq: directed vector table, corner sequences, random run against a queue-based model.
module tb_jtdsp16_pc_seq;

  localparam int K_NOP = 0, K_INC = 1, K_GJA = 2, K_CJA = 3, K_GB = 4, K_ICALL = 5, K_DO = 6;
  localparam int DEPTH = 4;
`ifdef JTDSP16_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, cen_i, goto_ja_i, call_ja_i, goto_b_i, icall_i, post_inc_i;
  logic [1:0]  b_field_i;
  logic [11:0] i_field_i;
  logic [15:0] pt_i;
  logic        con_result_i, do_en_i, ext_irq_i;
  logic [3:0]  do_ni_i;
  logic [6:0]  do_k_i;
  logic [15:0] rom_addr_o;
  logic        shadow_o, in_loop_o, stack_empty_o, stack_ovf_o;

  jtdsp16_pc_seq dut (
    .clk_i(clk_i), .rst_i(rst_i), .cen_i(cen_i), .goto_ja_i(goto_ja_i), .call_ja_i(call_ja_i),
    .goto_b_i(goto_b_i), .b_field_i(b_field_i), .icall_i(icall_i), .post_inc_i(post_inc_i),
    .i_field_i(i_field_i), .pt_i(pt_i), .con_result_i(con_result_i), .do_en_i(do_en_i),
    .do_ni_i(do_ni_i), .do_k_i(do_k_i), .ext_irq_i(ext_irq_i), .rom_addr_o(rom_addr_o),
    .shadow_o(shadow_o), .in_loop_o(in_loop_o), .stack_empty_o(stack_empty_o),
    .stack_ovf_o(stack_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int kind; bit con; bit [1:0] b; bit [15:0] arg; bit [3:0] ni; bit [6:0] k;
    bit [15:0] e_pc; bit e_sh; bit e_lp; bit e_em; bit e_ov;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(int kind, bit con, bit [1:0] b, bit [15:0] arg, bit [3:0] ni,
                              bit [6:0] k, bit [15:0] pc, bit sh, bit lp, bit em, bit ov);
    vec_t v;
    v.kind = kind; v.con = con; v.b = b; v.arg = arg; v.ni = ni; v.k = k;
    v.e_pc = pc; v.e_sh = sh; v.e_lp = lp; v.e_em = em; v.e_ov = ov;
    return v;
  endfunction

  // Reference model state: plain integers and a queue for the return stack.
  int m_pc, m_pi, l_start, l_end, l_cnt;
  bit m_ovf, m_loop, m_sh, m_busy;
  int stk[$];

  task automatic model_reset();
    m_pc = 0; m_pi = 0; m_ovf = 0; m_loop = 0; m_sh = 0; m_busy = 0;
    l_start = 0; l_end = 0; l_cnt = 0; stk.delete();
  endtask

  task automatic model_push(int v);
    stk.push_back(v);
    if (stk.size() > DEPTH) begin
      void'(stk.pop_front());
      m_ovf = 1;
    end
  endtask

  task automatic model_step(bit rst, bit cen, int kind, bit con, bit [1:0] b, bit [15:0] arg,
                            bit [3:0] ni, bit [6:0] k, bit irq);
    int nxt;
    bit is_br, exec, irq_ok, new_sh;
    if (rst) begin model_reset(); return; end
    if (!cen) return;
    nxt    = (m_pc + 1) % 65536;
    is_br  = (kind == K_GJA || kind == K_CJA || kind == K_GB || kind == K_ICALL);
    exec   = is_br && con;
    irq_ok = IRQ_EN && irq && !m_busy && !m_sh && !m_loop && kind == K_INC;
    new_sh = exec || kind == K_DO || irq_ok;
    if (irq_ok) begin
      m_pi = nxt; m_pc = 1; m_busy = 1;
    end else if (exec) begin
      m_loop = 0;
      case (kind)
        K_GJA: m_pc = (m_pc & 'hF000) | int'(arg[11:0]);
        K_CJA: begin model_push(nxt); m_pc = (m_pc & 'hF000) | int'(arg[11:0]); end
        K_ICALL: begin m_pi = nxt; m_pc = 2; end
        default: case (b)
          2'd0: m_pc = (stk.size() == 0) ? 0 : stk.pop_back();
          2'd1: begin m_pc = m_pi; m_busy = 0; end
          2'd2: m_pc = int'(arg);
          default: begin model_push(nxt); m_pc = int'(arg); end
        endcase
      endcase
    end else if (kind == K_DO && !m_loop) begin
      l_start = nxt; l_end = (m_pc + int'(ni)) % 65536; l_cnt = int'(k); m_loop = 1; m_pc = nxt;
    end else if (kind != K_NOP) begin
      if (m_loop && m_pc == l_end) begin
        if (l_cnt > 1) begin m_pc = l_start; l_cnt--; end
        else begin m_pc = nxt; m_loop = 0; end
      end else m_pc = nxt;
    end
    m_sh = new_sh;
  endtask

  task automatic set_in(int kind, bit con, bit [1:0] b, bit [15:0] arg, bit [3:0] ni, bit [6:0] k);
    goto_ja_i = (kind == K_GJA); call_ja_i = (kind == K_CJA); goto_b_i = (kind == K_GB);
    icall_i = (kind == K_ICALL); post_inc_i = (kind == K_INC); do_en_i = (kind == K_DO);
    con_result_i = con; b_field_i = b; i_field_i = arg[11:0]; pt_i = arg; do_ni_i = ni; do_k_i = k;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int pc, bit sh, bit lp, bit em, bit ov);
    chk({tag, ".rom_addr"}, int'(rom_addr_o), pc);
    chk({tag, ".shadow"}, int'(shadow_o), int'(sh));
    chk({tag, ".in_loop"}, int'(in_loop_o), int'(lp));
    chk({tag, ".stack_empty"}, int'(stack_empty_o), int'(em));
    chk({tag, ".stack_ovf"}, int'(stack_ovf_o), int'(ov));
  endtask

  initial begin
    rst_i = 1; cen_i = 1; ext_irq_i = 0;
    set_in(K_NOP, 1, 0, 0, 0, 0);
    tick(); tick();
    rst_i = 0;
    chk_all("reset", 0, 0, 0, 1, 0);

    for (int i = 0; i < 5; i++) tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'(i + 1), 0, 0, 1, 0));
    tbl.push_back(mk(K_GJA, 1, 0, 16'h010, 0, 0, 16'h0010, 1, 0, 1, 0));
    tbl.push_back(mk(K_CJA, 1, 0, 16'h123, 0, 0, 16'h0123, 1, 0, 0, 0));
    tbl.push_back(mk(K_GB,  1, 0, 0,       0, 0, 16'h0011, 1, 0, 1, 0));
    tbl.push_back(mk(K_INC, 1, 0, 0,       0, 0, 16'h0012, 0, 0, 1, 0));
    tbl.push_back(mk(K_GJA, 1, 0, 16'h020, 0, 0, 16'h0020, 1, 0, 1, 0));
    for (int i = 1; i <= 4; i++) tbl.push_back(mk(K_CJA, 1, 0, 16'(32 + i), 0, 0, 16'(32 + i), 1, 0, 0, 0));
    tbl.push_back(mk(K_CJA, 1, 0, 16'h025, 0, 0, 16'h0025, 1, 0, 0, 1));
    tbl.push_back(mk(K_GB,  1, 0, 0, 0, 0, 16'h0025, 1, 0, 0, 1));
    tbl.push_back(mk(K_GB,  1, 0, 0, 0, 0, 16'h0024, 1, 0, 0, 1));
    tbl.push_back(mk(K_GB,  1, 0, 0, 0, 0, 16'h0023, 1, 0, 0, 1));
    tbl.push_back(mk(K_GB,  1, 0, 0, 0, 0, 16'h0022, 1, 0, 1, 1));
    tbl.push_back(mk(K_GB,  1, 0, 0, 0, 0, 16'h0000, 1, 0, 1, 1));
    tbl.push_back(mk(K_GJA, 1, 0, 16'h040, 0, 0, 16'h0040, 1, 0, 1, 1));
    tbl.push_back(mk(K_DO,  1, 0, 0, 3, 2, 16'h0041, 1, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0042, 0, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0043, 0, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0041, 0, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0042, 0, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0043, 0, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0044, 0, 0, 1, 1));
    tbl.push_back(mk(K_GJA, 1, 0, 16'h040, 0, 0, 16'h0040, 1, 0, 1, 1));
    tbl.push_back(mk(K_DO,  1, 0, 0, 3, 2, 16'h0041, 1, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0042, 0, 1, 1, 1));
    tbl.push_back(mk(K_GJA, 0, 0, 16'h080, 0, 0, 16'h0043, 0, 1, 1, 1));
    tbl.push_back(mk(K_GJA, 1, 0, 16'h080, 0, 0, 16'h0080, 1, 0, 1, 1));
    tbl.push_back(mk(K_ICALL, 1, 0, 0, 0, 0, 16'h0002, 1, 0, 1, 1));
    tbl.push_back(mk(K_GB,  1, 1, 0, 0, 0, 16'h0081, 1, 0, 1, 1));
    tbl.push_back(mk(K_GB,  1, 3, 16'h1234, 0, 0, 16'h1234, 1, 0, 0, 1));
    tbl.push_back(mk(K_GJA, 1, 0, 16'h056, 0, 0, 16'h1056, 1, 0, 0, 1));
    tbl.push_back(mk(K_GB,  1, 2, 16'h0500, 0, 0, 16'h0500, 1, 0, 0, 1));
    tbl.push_back(mk(K_GB,  1, 0, 0, 0, 0, 16'h0082, 1, 0, 1, 1));
    tbl.push_back(mk(K_NOP, 1, 0, 0, 0, 0, 16'h0082, 0, 0, 1, 1));
    tbl.push_back(mk(K_GB,  1, 2, 16'hFFFF, 0, 0, 16'hFFFF, 1, 0, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1));
    tbl.push_back(mk(K_GJA, 1, 0, 16'h060, 0, 0, 16'h0060, 1, 0, 1, 1));
    tbl.push_back(mk(K_DO,  1, 0, 0, 2, 3, 16'h0061, 1, 1, 1, 1));
    tbl.push_back(mk(K_DO,  1, 0, 0, 5, 9, 16'h0062, 1, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0061, 0, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0062, 0, 1, 1, 1));
    tbl.push_back(mk(K_GB,  0, 0, 0, 0, 0, 16'h0061, 0, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0062, 0, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0063, 0, 0, 1, 1));
    tbl.push_back(mk(K_GB,  1, 2, 16'hFFFE, 0, 0, 16'hFFFE, 1, 0, 1, 1));
    tbl.push_back(mk(K_DO,  1, 0, 0, 2, 2, 16'hFFFF, 1, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'hFFFF, 0, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 1));
    tbl.push_back(mk(K_INC, 1, 0, 0, 0, 0, 16'h0001, 0, 0, 1, 1));

    foreach (tbl[i]) begin
      set_in(tbl[i].kind, tbl[i].con, tbl[i].b, tbl[i].arg, tbl[i].ni, tbl[i].k);
      tick();
      chk_all($sformatf("vec%0d", i), int'(tbl[i].e_pc), tbl[i].e_sh, tbl[i].e_lp, tbl[i].e_em, tbl[i].e_ov);
    end

    // Clock enable low freezes everything, including shadow.
    set_in(K_GJA, 1, 0, 16'h077, 0, 0); tick();
    chk_all("cen_pre", 'h77, 1, 0, 1, 1);
    cen_i = 0; set_in(K_INC, 1, 0, 0, 0, 0);
    tick(); tick();
    chk_all("cen_hold", 'h77, 1, 0, 1, 1);
    cen_i = 1; tick();
    chk_all("cen_resume", 'h78, 0, 0, 1, 1);

    // Reset in the middle of a loop with a live stack entry.
    set_in(K_CJA, 1, 0, 16'h040, 0, 0); tick();
    chk_all("rst_pre_call", 'h40, 1, 0, 0, 1);
    set_in(K_DO, 1, 0, 0, 3, 2); tick();
    chk_all("rst_pre_do", 'h41, 1, 1, 0, 1);
    rst_i = 1; set_in(K_INC, 1, 0, 0, 0, 0); tick();
    rst_i = 0;
    chk_all("rst_mid", 0, 0, 0, 1, 0);

`ifdef JTDSP16_IRQ_EN
    set_in(K_GJA, 1, 0, 16'h030, 0, 0); tick();
    set_in(K_NOP, 1, 0, 0, 0, 0); tick();
    chk_all("irq_pre", 'h30, 0, 0, 1, 0);
    ext_irq_i = 1; set_in(K_INC, 1, 0, 0, 0, 0); tick();
    chk_all("irq_entry", 1, 1, 0, 1, 0);
    tick();
    chk_all("irq_shadow_block", 2, 0, 0, 1, 0);
    tick();
    chk_all("irq_busy_block", 3, 0, 0, 1, 0);
    set_in(K_GB, 1, 1, 0, 0, 0); tick();
    chk_all("irq_return", 'h31, 1, 0, 1, 0);
    ext_irq_i = 0;
`endif

    rst_i = 1; set_in(K_NOP, 1, 0, 0, 0, 0); tick();
    rst_i = 0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int r, kind;
      bit r_rst, r_cen, r_con, r_irq;
      bit [1:0] r_b;
      bit [15:0] r_arg;
      bit [3:0] r_ni;
      bit [6:0] r_k;
      r = $urandom_range(0, 99);
      kind = (r < 45) ? K_INC : (r < 52) ? K_NOP : (r < 60) ? K_DO : (r < 68) ? K_GJA :
             (r < 74) ? K_CJA : (r < 90) ? K_GB : (r < 94) ? K_ICALL : K_INC;
      r_rst = ($urandom_range(0, 199) == 0);
      r_cen = ($urandom_range(0, 9) != 0);
      r_con = ($urandom_range(0, 4) != 0);
      r_irq = 1'($urandom_range(0, 1));
      r_b   = 2'($urandom_range(0, 3));
      r_arg = 16'($urandom);
      r_ni  = 4'($urandom_range(1, 15));
      r_k   = 7'($urandom_range(2, 4));
      rst_i = r_rst; cen_i = r_cen; ext_irq_i = r_irq;
      set_in(kind, r_con, r_b, r_arg, r_ni, r_k);
      model_step(r_rst, r_cen, kind, r_con, r_b, r_arg, r_ni, r_k, r_irq);
      tick();
      chk_all($sformatf("rnd%0d", c), m_pc, m_sh, m_loop, stk.size() == 0, m_ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
